// File: rtl/opsum_fifo_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : opsum_fifo_drain_if
// Brief    : Opsum FIFO read side plus GLB valid/ready write port, grouped
//            for the opsum drain engine.
// Revision : 1.0 - initial release
// ============================================================================
interface opsum_fifo_drain_if #(
  parameter int NUM_FIFO = 32,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 32
);
  // FIFO side: FWFT heads, empty flags, one-hot pop
  logic [NUM_FIFO-1:0]        opsum_fifo_empty_i;
  logic [NUM_FIFO*DATA_W-1:0] opsum_fifo_data_i;
  logic [NUM_FIFO-1:0]        opsum_fifo_pop_matrix_o;
  // GLB write side
  logic                       glb_write_valid_o;
  logic                       glb_write_ready_i;
  logic [ADDR_W-1:0]          glb_write_addr_o;
  logic [DATA_W-1:0]          glb_write_data_o;

  // The drain engine
  modport master (
    input  opsum_fifo_empty_i,
    input  opsum_fifo_data_i,
    output opsum_fifo_pop_matrix_o,
    output glb_write_valid_o,
    input  glb_write_ready_i,
    output glb_write_addr_o,
    output glb_write_data_o
  );

  // FIFO bank and GLB
  modport slave (
    output opsum_fifo_empty_i,
    output opsum_fifo_data_i,
    input  opsum_fifo_pop_matrix_o,
    input  glb_write_valid_o,
    output glb_write_ready_i,
    input  glb_write_addr_o,
    input  glb_write_data_o
  );
endinterface
`default_nettype wire

// File: rtl/opsum_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : opsum_fifo_drain
// Brief    : Drains the per-output-channel opsum FIFOs one word at a time
//            under round-robin arbitration and writes each word to the GLB
//            at base + lane*stride + lane_count*word_bytes.
// Revision : 1.0 - initial release
// ============================================================================
module opsum_fifo_drain #(
  parameter int         NUM_FIFO        = 32,
  parameter int         DATA_W          = 16,
  parameter int         ADDR_W          = 32,
  parameter int         CNT_W           = 16,
  parameter logic [1:0] LAYER_POINTWISE = 2'd0,
  parameter logic [1:0] LAYER_DEPTHWISE = 2'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        layer_type_i,
  input  logic              opsum_fifo_reset_i,
  input  logic              drain_start_i,
  input  logic              flush_i,
  input  logic [7:0]        OC_real_i,
  input  logic [ADDR_W-1:0] ofmap_base_i,
  input  logic [ADDR_W-1:0] oc_stride_i,
  opsum_fifo_drain_if.master fifo_glb,
  output logic              drain_busy_o,
  output logic              drain_done_o
);

  localparam int PTR_W      = $clog2(NUM_FIFO);
  localparam int DW_LANES   = 10;          // depthwise uses at most 10 lanes
  localparam int WORD_BYTES = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    POP   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state, state_next;
  logic [NUM_FIFO-1:0] mask;
  logic [NUM_FIFO-1:0] start_mask;
  logic [NUM_FIFO-1:0] cand;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    sel;
  logic [PTR_W-1:0]    pick;
  logic                found;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   data;
  logic [CNT_W-1:0]    cnt [NUM_FIFO];

  // Enable mask to latch at start: lanes below OC_real, limited by layer type
  always_comb begin
    start_mask = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (layer_type_i == LAYER_POINTWISE)
        start_mask[i] = (int'(OC_real_i) > i);
      else if (layer_type_i == LAYER_DEPTHWISE)
        start_mask[i] = (int'(OC_real_i) > i) && (i < DW_LANES);
    end
  end

  assign cand = mask & ~fifo_glb.opsum_fifo_empty_i;

  // Round-robin pick: first candidate at or above rr_ptr, wrapping; the
  // descending loop leaves the lowest offset from rr_ptr as the winner
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_FIFO - 1; i >= 0; i--) begin
      if (cand[(int'(rr_ptr) + i) % NUM_FIFO]) begin
        found = 1'b1;
        pick  = PTR_W'((int'(rr_ptr) + i) % NUM_FIFO);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (drain_start_i) state_next = SCAN;
      SCAN: begin
        if (found)        state_next = POP;
        else if (flush_i) state_next = DONE;
      end
      POP:     state_next = WRITE;
      WRITE:   if (fifo_glb.glb_write_ready_i) state_next = SCAN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (opsum_fifo_reset_i) state_next = IDLE;
  end

  // Moore outputs decoded from the current state
  always_comb begin
    fifo_glb.opsum_fifo_pop_matrix_o = '0;
    if (state == POP) fifo_glb.opsum_fifo_pop_matrix_o = NUM_FIFO'(1) << sel;
  end

  assign fifo_glb.glb_write_valid_o = (state == WRITE);
  assign fifo_glb.glb_write_addr_o  = addr;
  assign fifo_glb.glb_write_data_o  = data;
  assign drain_busy_o               = (state != IDLE);
  assign drain_done_o               = (state == DONE);

  // Datapath: mask, arbitration pointer, captured word/address, lane counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask   <= '0;
      rr_ptr <= '0;
      sel    <= '0;
      addr   <= '0;
      data   <= '0;
      for (int i = 0; i < NUM_FIFO; i++) cnt[i] <= '0;
    end else if (opsum_fifo_reset_i) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_FIFO; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (drain_start_i) begin
            mask   <= start_mask;
            rr_ptr <= '0;
            for (int i = 0; i < NUM_FIFO; i++) cnt[i] <= '0;
          end
        end
        SCAN: if (found) sel <= pick;
        POP: begin
          data <= fifo_glb.opsum_fifo_data_i[int'(sel)*DATA_W +: DATA_W];
          addr <= ofmap_base_i
                + ADDR_W'(sel) * oc_stride_i
                + ADDR_W'(cnt[sel]) * ADDR_W'(WORD_BYTES);
        end
        WRITE: begin
          if (fifo_glb.glb_write_ready_i) begin
            cnt[sel] <= cnt[sel] + CNT_W'(1);
            rr_ptr   <= (sel == PTR_W'(NUM_FIFO - 1)) ? '0 : sel + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opsum_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_opsum_fifo_drain
// Brief    : Directed self-checking bench for opsum_fifo_drain with a simple
//            FIFO-bank model and a GLB write log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opsum_fifo_drain;
  localparam int NF = 32;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam logic [1:0] PW = 2'd0;
  localparam logic [1:0] DWL = 2'd1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    layer_type;
  logic          abort;
  logic          drain_start;
  logic          flush;
  logic [7:0]    oc_real;
  logic [AW-1:0] base;
  logic [AW-1:0] stride;
  logic          busy;
  logic          done;

  opsum_fifo_drain_if #(.NUM_FIFO(NF), .DATA_W(DW), .ADDR_W(AW)) bus ();

  opsum_fifo_drain #(.NUM_FIFO(NF), .DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .layer_type_i       (layer_type),
    .opsum_fifo_reset_i (abort),
    .drain_start_i      (drain_start),
    .flush_i            (flush),
    .OC_real_i          (oc_real),
    .ofmap_base_i       (base),
    .oc_stride_i        (stride),
    .fifo_glb           (bus),
    .drain_busy_o       (busy),
    .drain_done_o       (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int loaded [NF];   // words ever pushed per lane (written by stimulus only)
  int pops   [NF];   // words ever popped per lane (written by monitor only)
  int pb     [NF];   // snapshot of pops at start of a step
  int bad_pops;
  int cyc;
  int done_seen;
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            wr_cyc  [$];

  // FIFO bank model: head word encodes {lane, per-lane pop index}
  always_comb begin
    for (int l = 0; l < NF; l++) begin
      bus.opsum_fifo_empty_i[l]           = (loaded[l] == pops[l]);
      bus.opsum_fifo_data_i[l*DW +: DW]   = {l[7:0], pops[l][7:0]};
    end
  end

  // Monitor: pops, illegal pops, GLB writes, done pulses
  always @(posedge clk) begin : mon
    int bad;
    if (!rst_n) begin
      for (int l = 0; l < NF; l++) pops[l] <= 0;
      bad_pops  <= 0;
      cyc       <= 0;
      done_seen <= 0;
    end else begin
      bad = 0;
      cyc <= cyc + 1;
      if (bus.glb_write_valid_o && bus.glb_write_ready_i) begin
        wr_addr.push_back(bus.glb_write_addr_o);
        wr_data.push_back(bus.glb_write_data_o);
        wr_cyc.push_back(cyc);
      end
      if (done) done_seen <= done_seen + 1;
      if ($countones(bus.opsum_fifo_pop_matrix_o) > 1) bad++;
      for (int l = 0; l < NF; l++) begin
        if (bus.opsum_fifo_pop_matrix_o[l]) begin
          pops[l] <= pops[l] + 1;
          if (loaded[l] == pops[l]) bad++;
        end
      end
      bad_pops <= bad_pops + bad;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] hw(input int lane, input int idx);
    return {lane[7:0], idx[7:0]};
  endfunction

  task automatic snap();
    for (int l = 0; l < NF; l++) pb[l] = pops[l];
  endtask

  task automatic start(input logic [1:0] lt, input logic [7:0] oc);
    @(negedge clk);
    layer_type  = lt;
    oc_real     = oc;
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    chk(tag, 64'(seen), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.glb_write_valid_o) begin seen = 1; break; end
      @(negedge clk);
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (wr_addr.size() >= target) begin seen = 1; break; end
      @(negedge clk);
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  // Directed sequence
  initial begin
    int n0, d0;
    logic [AW-1:0] exp_a [4];
    int            exp_l [4];
    int            exp_k [4];

    rst_n = 1'b0; layer_type = PW; abort = 1'b0; drain_start = 1'b0;
    flush = 1'b0; oc_real = 8'd0; base = 32'h1000; stride = 32'h100;
    bus.glb_write_ready_i = 1'b0;
    for (int l = 0; l < NF; l++) loaded[l] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_valid", 64'(bus.glb_write_valid_o), 64'd0);
    chk("rst_pop",   64'(bus.opsum_fifo_pop_matrix_o), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_addr",  64'(bus.glb_write_addr_o), 64'd0);
    chk("rst_data",  64'(bus.glb_write_data_o), 64'd0);

    // Pointwise, lanes 0..3 one word each, flush high
    flush = 1'b1; bus.glb_write_ready_i = 1'b1;
    snap(); n0 = wr_addr.size(); d0 = done_seen;
    for (int l = 0; l < 4; l++) loaded[l] = pops[l] + 1;
    start(PW, 8'd4);
    wait_done("t1_done", 60);
    chk("t1_nwr", 64'(wr_addr.size() - n0), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_addr%0d", k), 64'(wr_addr[n0+k]), 64'(32'h1000 + k*32'h100));
      chk($sformatf("t1_data%0d", k), 64'(wr_data[n0+k]), 64'(hw(k, pb[k])));
      chk($sformatf("t1_pops%0d", k), 64'(pops[k] - pb[k]), 64'd1);
    end
    chk("t1_done_cnt", 64'(done_seen - d0), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);

    // Round-robin: lanes 1 and 3 with two words each
    snap(); n0 = wr_addr.size();
    loaded[1] = pops[1] + 2; loaded[3] = pops[3] + 2;
    exp_a = '{32'h1100, 32'h1300, 32'h1102, 32'h1302};
    exp_l = '{1, 3, 1, 3};
    exp_k = '{0, 0, 1, 1};
    start(PW, 8'd4);
    wait_done("t2_done", 80);
    chk("t2_nwr", 64'(wr_addr.size() - n0), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_addr%0d", k), 64'(wr_addr[n0+k]), 64'(exp_a[k]));
      chk($sformatf("t2_data%0d", k), 64'(wr_data[n0+k]),
          64'(hw(exp_l[k], pb[exp_l[k]] + exp_k[k])));
    end
    for (int k = 1; k < 4; k++)
      chk($sformatf("t2_gap%0d", k), 64'(wr_cyc[n0+k] - wr_cyc[n0+k-1]), 64'd3);

    // Backpressure on lane 2; a start pulse during WRITE must be ignored
    flush = 1'b0; bus.glb_write_ready_i = 1'b0;
    snap(); n0 = wr_addr.size();
    loaded[2] = pops[2] + 1;
    start(PW, 8'd4);
    wait_valid("t3_valid_rise", 20);
    chk("t3_addr", 64'(bus.glb_write_addr_o), 64'h1200);
    chk("t3_data", 64'(bus.glb_write_data_o), 64'(hw(2, pb[2])));
    loaded[2] = loaded[2] + 1;
    drain_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drain_start = 1'b0;
      chk($sformatf("t3_hold_valid%0d", i), 64'(bus.glb_write_valid_o), 64'd1);
      chk($sformatf("t3_hold_addr%0d", i),  64'(bus.glb_write_addr_o), 64'h1200);
      chk($sformatf("t3_hold_data%0d", i),  64'(bus.glb_write_data_o), 64'(hw(2, pb[2])));
      chk($sformatf("t3_hold_pop%0d", i),   64'(bus.opsum_fifo_pop_matrix_o), 64'd0);
    end
    chk("t3_pops_held", 64'(pops[2] - pb[2]), 64'd1);
    bus.glb_write_ready_i = 1'b1;
    wait_writes("t3_writes", n0 + 2, 30);
    chk("t3_addr0", 64'(wr_addr[n0]),   64'h1200);
    chk("t3_addr1", 64'(wr_addr[n0+1]), 64'h1202);
    chk("t3_data1", 64'(wr_data[n0+1]), 64'(hw(2, pb[2] + 1)));
    flush = 1'b1;
    wait_done("t3_done", 30);
    chk("t3_busy", 64'(busy), 64'd0);

    // Depthwise, OC_real=32: lane 10 lies outside the 10-lane limit
    snap(); n0 = wr_addr.size();
    loaded[9] = pops[9] + 1; loaded[10] = pops[10] + 1;
    start(DWL, 8'd32);
    wait_done("t4_done", 40);
    chk("t4_nwr",    64'(wr_addr.size() - n0), 64'd1);
    chk("t4_addr",   64'(wr_addr[n0]), 64'h1900);
    chk("t4_pops9",  64'(pops[9] - pb[9]), 64'd1);
    chk("t4_pops10", 64'(pops[10] - pb[10]), 64'd0);
    loaded[10] = pops[10];

    // OC_real=0: SCAN then DONE, no pops even with a non-empty lane
    snap(); n0 = wr_addr.size(); d0 = done_seen;
    loaded[5] = pops[5] + 1;
    start(PW, 8'd0);
    chk("t5_scan_done", 64'(done), 64'd0);
    chk("t5_scan_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t5_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("t5_after_done", 64'(done), 64'd0);
    chk("t5_after_busy", 64'(busy), 64'd0);
    chk("t5_nwr",  64'(wr_addr.size() - n0), 64'd0);
    chk("t5_pops", 64'(pops[5] - pb[5]), 64'd0);
    chk("t5_done_cnt", 64'(done_seen - d0), 64'd1);
    loaded[5] = pops[5];

    // Abort during a stalled WRITE, then restart from the base address
    flush = 1'b0; bus.glb_write_ready_i = 1'b0;
    n0 = wr_addr.size();
    loaded[0] = pops[0] + 1;
    start(PW, 8'd4);
    wait_valid("t6_valid_rise", 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_valid_drop", 64'(bus.glb_write_valid_o), 64'd0);
    chk("t6_busy",       64'(busy), 64'd0);
    chk("t6_pop",        64'(bus.opsum_fifo_pop_matrix_o), 64'd0);
    chk("t6_no_write",   64'(wr_addr.size() - n0), 64'd0);
    snap();
    loaded[0] = pops[0] + 1;
    flush = 1'b1; bus.glb_write_ready_i = 1'b1;
    start(PW, 8'd4);
    wait_done("t6_done", 40);
    chk("t6_nwr",  64'(wr_addr.size() - n0), 64'd1);
    chk("t6_addr", 64'(wr_addr[n0]), 64'h1000);
    chk("t6_data", 64'(wr_data[n0]), 64'(hw(0, pb[0])));

    chk("bad_pops", 64'(bad_pops), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/opsum_fifo_drain.md
Name: opsum_fifo_drain

Overview:
- Read-side counterpart of the opsum FIFO push masking.
- Drains the 32 per-output-channel opsum FIFOs one word at a time under round-robin arbitration, and writes each word to the GLB through a valid/ready write port with a per-channel address.
- Runs after a token-engine tile starts. Reports completion once flush is requested and every enabled FIFO is empty.

Parameters:
- NUM_FIFO, 32, number of opsum FIFOs / output-channel lanes.
- DATA_W, 16, opsum word width.
- ADDR_W, 32, GLB byte address width.
- CNT_W, 16, per-lane write counter width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- layer_type_i  input  2  `POINTWISE` or `DEPTHWISE`.
- opsum_fifo_reset_i  input  1  synchronous abort/clear.
- drain_start_i  input  1  start pulse; only accepted in IDLE.
- flush_i  input  1  level; last opsum has been pushed.
- OC_real_i  input  8  active lane count (0..32).
- ofmap_base_i  input  ADDR_W  GLB base address.
- oc_stride_i  input  ADDR_W  byte stride between lanes.
- opsum_fifo_empty_i  input  NUM_FIFO  per-FIFO empty flags.
- opsum_fifo_data_i  input  NUM_FIFO*DATA_W  FWFT head data; lane i is bits [i*DATA_W +: DATA_W].
- opsum_fifo_pop_matrix_o  output  NUM_FIFO  one-hot pop.
- glb_write_valid_o  output  1  write request.
- glb_write_ready_i  input  1  GLB accepts.
- glb_write_addr_o  output  ADDR_W  write address.
- glb_write_data_o  output  DATA_W  write data.
- drain_busy_o  output  1  high in any state except IDLE.
- drain_done_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: every output 0; state IDLE; rr_ptr 0; all lane counters 0; enable mask 0.
- Enable mask, latched in IDLE on drain_start_i:
  - static = (OC_real_i == 0) ? 0 : low min(OC_real_i, 32) bits set.
  - `POINTWISE`: mask = static.
  - `DEPTHWISE`: mask = static & 32'h0000_03FF.
  - Any other layer type: mask = 0.
- Also on drain_start_i in IDLE: clear all lane counters and set rr_ptr = 0.
- FSM states: IDLE, SCAN, POP, WRITE, DONE.
- IDLE:
  - drain_start_i -> SCAN.
- SCAN:
  - cand = mask & ~opsum_fifo_empty_i.
  - If cand != 0: sel = first set bit scanning from rr_ptr upward, wrapping 31 -> 0; go to POP.
  - Else if flush_i: go to DONE.
  - Else stay in SCAN.
- POP (exactly one cycle):
  - opsum_fifo_pop_matrix_o = 1 << sel.
  - Register data = lane sel head word.
  - Register addr = ofmap_base_i + sel*oc_stride_i + cnt[sel]*(DATA_W/8), modulo 2^ADDR_W.
  - Go to WRITE.
- WRITE:
  - glb_write_valid_o = 1; addr and data held stable until glb_write_ready_i.
  - On ready (same cycle): cnt[sel]++ (wraps at 2^CNT_W); rr_ptr = (sel+1) mod NUM_FIFO; go to SCAN.
  - The next valid rises no earlier than 2 cycles later.
- DONE:
  - drain_done_o = 1 for one cycle, then IDLE.
  - Counters are kept until the next start.
- Throughput: at most 1 word per 3 cycles; ready held high gives exactly 3.
- Pop vs. write relation:
  - Pop is never asserted outside POP, and never on an empty or masked lane.
  - Each pop is followed by exactly one GLB write.
- Priority and abort:
  - opsum_fifo_reset_i has priority over every state. Next cycle: state IDLE, valid/pop/done = 0, counters and rr_ptr cleared.
  - A pending write is dropped on abort.
- Other boundary rules:
  - drain_start_i outside IDLE is ignored.
  - flush_i rising while cand != 0 does not end the drain; all remaining words drain first.
  - Lanes outside the mask are never popped, even if non-empty.
  - OC_real_i, ofmap_base_i and oc_stride_i must be stable while drain_busy_o is high.

Test Plan:
- Pointwise, OC_real=4, base=0x1000, stride=0x100, one word each in lanes 0..3, flush high -> writes in order to 0x1000, 0x1100, 0x1200, 0x1300, one pop each, drain_done_o after the 4th write.
- Round-robin: lanes 1 and 3 hold 2 words each, ready always high -> lane order 1, 3, 1, 3; addresses 0x1100, 0x1300, 0x1102, 0x1302; valid rises every 3 cycles.
- Backpressure: ready low for 5 cycles in WRITE -> valid, addr and data held constant, no extra pop, counter unchanged until ready.
- Depthwise, OC_real=32, lanes 9 and 10 non-empty -> only lane 9 drained; lane 10 never popped; done pulses once lane 9 is empty and flush is high.
- OC_real=0, flush high, drain_start -> SCAN then DONE, done pulse after 2 cycles, zero pops and zero writes.
- Abort: opsum_fifo_reset_i asserted during WRITE with ready low -> valid drops next cycle, state IDLE; a new start writes again at the base addresses (counters cleared).
